// File: rtl/y86_defs.sv
// Shared Y86-64 definitions for the memory stage: instruction codes,
// memory-stage state encoding and icode classification helpers.
package y86_defs;

   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Bytes moved per 64-bit access, one byte per transfer cycle.
   localparam int WORD_BYTES = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Instructions that store a word to data memory.
   function automatic logic is_write(input logic [3:0] ic);
      case (ic)
         IRMMOVQ, ICALL, IPUSHQ: is_write = 1'b1;
         default:                is_write = 1'b0;
      endcase
   endfunction

   // Instructions that load a word from data memory.
   function automatic logic is_read(input logic [3:0] ic);
      case (ic)
         IMRMOVQ, IRET, IPOPQ: is_read = 1'b1;
         default:              is_read = 1'b0;
      endcase
   endfunction

   function automatic logic is_access(input logic [3:0] ic);
      is_access = is_write(ic) | is_read(ic);
   endfunction

   // ret/popq address the stack through valA (old %rsp); all others use valE.
   function automatic logic addr_from_vala(input logic [3:0] ic);
      case (ic)
         IRET, IPOPQ: addr_from_vala = 1'b1;
         default:     addr_from_vala = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide single-port data memory, synchronous read-first.
// Contents are not affected by reset.
module dmem_byte_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_r [DEPTH];

   // Single port: old contents are returned when writing the same address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
      rdata <= mem_r[addr];
   end

endmodule

// File: rtl/memory_access.sv
// Y86-64 SEQ memory stage. Accepts one request per start pulse while idle,
// range-checks the word address, then moves one byte per cycle between the
// latched request and the byte RAM. Results are held until the next accept.
module memory_access
   import y86_defs::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   output logic [63:0] valM,
   output logic        done,
   output logic        busy,
   output logic        dmem_error
);

   localparam int AW = $clog2(DEPTH);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [2:0]          cnt_r;
   logic [3:0]          icode_r;
   logic [AW-1:0]       addr_idx_r;
   logic [63:0]         wdata_r;
   logic [63:0]         valm_r;
   logic                done_r;
   logic                busy_r;
   logic                err_r;

   logic                done_nxt_s;
   logic                busy_nxt_s;
   logic                accept_s;
   logic                last_s;
   logic [ADDR_W-1:0]   acc_addr_s;
   logic [63:0]         acc_wdata_s;
   logic [ADDR_W:0]     addr_ext_s;
   logic [ADDR_W:0]     addr_end_s;
   logic                range_err_s;
   logic                req_err_s;

   logic [AW-1:0]       ram_addr_s;
   logic                ram_we_s;
   logic [7:0]          ram_wdata_s;
   logic [7:0]          ram_rdata_s;

   assign accept_s = (state_r == S_IDLE) && start;
   assign last_s   = (cnt_r == 3'(WORD_BYTES - 1));

   // Request decode: address/data mux and range check on the live inputs.
   // The extra top bit keeps addr+7 from wrapping for addresses near 2^64.
   always_comb begin
      acc_addr_s  = addr_from_vala(icode) ? valA[ADDR_W-1:0] : valE[ADDR_W-1:0];
      acc_wdata_s = (icode == ICALL) ? valP : valA;
      addr_ext_s  = {1'b0, acc_addr_s};
      addr_end_s  = addr_ext_s + (ADDR_W+1)'(WORD_BYTES - 1);
      range_err_s = (addr_end_s > (ADDR_W+1)'(DEPTH - 1)) ||
                    (addr_ext_s >= (ADDR_W+1)'(DEPTH));
      req_err_s   = is_access(icode) && range_err_s;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: errors and no-access ops skip straight to DONE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               if (!is_access(icode) || range_err_s) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_XFER;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_XFER: begin
            if (last_s) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_XFER;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // FSM outputs, computed from the next state so the flops track the state.
   always_comb begin
      done_nxt_s = (state_nxt_s == S_DONE);
      busy_nxt_s = (state_nxt_s != S_IDLE);
   end

   // Registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= done_nxt_s;
         busy_r <= busy_nxt_s;
      end
   end

   // Request latch, byte counter, valM assembly and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         icode_r    <= 4'h0;
         addr_idx_r <= '0;
         wdata_r    <= 64'h0;
         cnt_r      <= 3'd0;
         valm_r     <= 64'h0;
         err_r      <= 1'b0;
      end else if (accept_s) begin
         icode_r    <= icode;
         addr_idx_r <= AW'(acc_addr_s);
         wdata_r    <= acc_wdata_s;
         cnt_r      <= 3'd0;
         valm_r     <= 64'h0;
         err_r      <= req_err_s;
      end else if (state_r == S_XFER) begin
         cnt_r <= cnt_r + 3'd1;
         if (!is_write(icode_r)) begin
            valm_r[{cnt_r, 3'b000} +: 8] <= ram_rdata_s;
         end
      end
   end

   // RAM port steering. Reads run one byte ahead: the RAM output during
   // XFER k is M[addr+k], fetched on the previous edge (the accept edge for
   // k=0), so the last byte lands in valM on the edge that enters DONE.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_wdata_s = wdata_r[{cnt_r, 3'b000} +: 8];
      ram_addr_s  = addr_idx_r;
      case (state_r)
         S_IDLE: ram_addr_s = AW'(acc_addr_s);
         S_XFER: begin
            if (is_write(icode_r)) begin
               ram_we_s   = 1'b1;
               ram_addr_s = addr_idx_r + AW'(cnt_r);
            end else begin
               ram_we_s   = 1'b0;
               ram_addr_s = addr_idx_r + AW'(cnt_r) + AW'(1'b1);
            end
         end
         S_DONE:  ram_addr_s = addr_idx_r;
         default: ram_addr_s = addr_idx_r;
      endcase
   end

   dmem_byte_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr_s),
      .we    (ram_we_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign valM       = valm_r;
   assign done       = done_r;
   assign busy       = busy_r;
   assign dmem_error = err_r;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: requests push their expected
// result onto a scoreboard; the entry is popped and compared when done fires.
module tb_memory_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  icode;
   logic [63:0] valE;
   logic [63:0] valA;
   logic [63:0] valP;
   logic [63:0] valM;
   logic        done;
   logic        busy;
   logic        dmem_error;

   int checks = 0;
   int errors = 0;

   localparam int LAT_ACC   = 9;
   localparam int LAT_NOACC = 1;
   localparam int LAT_MAX   = 30;

   typedef struct {
      logic [63:0] valm;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   memory_access #(.DEPTH(1024), .ADDR_W(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .icode      (icode),
      .valE       (valE),
      .valA       (valA),
      .valP       (valP),
      .valM       (valM),
      .done       (done),
      .busy       (busy),
      .dmem_error (dmem_error)
   );

   // Issue one request from an idle DUT, scramble inputs after accept, wait
   // for done, compare against the scoreboard, then step into IDLE.
   task automatic run_req(input logic [3:0] ic, input logic [63:0] e,
                          input logic [63:0] a, input logic [63:0] p,
                          input logic [63:0] exp_valm, input logic exp_err,
                          input int exp_lat, input string name);
      exp_t x;
      int lat;
      x.valm = exp_valm; x.err = exp_err; x.lat = exp_lat; x.name = name;
      sb_q.push_back(x);
      icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      icode = 4'(ic + 4'd1);
      valE  = {$urandom, $urandom};
      valA  = {$urandom, $urandom};
      valP  = {$urandom, $urandom};
      lat = 1;
      while (done !== 1'b1 && lat < LAT_MAX) begin
         @(posedge clk); #1;
         lat++;
      end
      x = sb_q.pop_front();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: done=%b after %0d cycles, required 1", x.name, done, lat);
      end else begin
         checks++;
         if (lat !== x.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", x.name, lat, x.lat);
         end
         checks++;
         if (valM !== x.valm) begin
            errors++;
            $display("FAIL %s valM: got %h required %h", x.name, valM, x.valm);
         end
         checks++;
         if (dmem_error !== x.err) begin
            errors++;
            $display("FAIL %s dmem_error: got %b required %b", x.name, dmem_error, x.err);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: done=%b busy=%b required 0 0", x.name, done, busy);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({valM, done, busy, dmem_error} !== 67'h0) begin
         errors++;
         $display("FAIL reset_values: valM=%h done=%b busy=%b err=%b required all 0",
                  valM, done, busy, dmem_error);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      run_req(4'h4, 64'h10, 64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b0, LAT_ACC, "rmmovq_wr");
      run_req(4'h5, 64'h10, 64'h0, 64'h0, 64'h0123456789ABCDEF, 1'b0, LAT_ACC, "mrmovq_rd");
      // Unaligned read shows the little-endian byte order and untouched M[0x18].
      run_req(4'h5, 64'h11, 64'h0, 64'h0, 64'h000123456789ABCD, 1'b0, LAT_ACC, "mrmovq_unaligned");
      run_req(4'h5, 64'h0C, 64'h0, 64'h0, 64'h89ABCDEF00000000, 1'b0, LAT_ACC, "mrmovq_low_edge");
   endtask

   task automatic test_call_ret();
      run_req(4'h8, 64'h3F8, 64'hDEAD, 64'h42, 64'h0, 1'b0, LAT_ACC, "call_wr");
      run_req(4'h9, 64'h0, 64'h3F8, 64'h0, 64'h42, 1'b0, LAT_ACC, "ret_rd");
   endtask

   task automatic test_range();
      run_req(4'h5, 64'h3F8, 64'h0, 64'h0, 64'h42, 1'b0, LAT_ACC, "range_last_ok");
      run_req(4'h5, 64'h3F9, 64'h0, 64'h0, 64'h0, 1'b1, LAT_NOACC, "range_rd_over");
      run_req(4'h4, 64'h3F9, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1'b1, LAT_NOACC, "range_wr_over");
      run_req(4'h5, 64'h3F8, 64'h0, 64'h0, 64'h42, 1'b0, LAT_ACC, "range_mem_unchanged");
      run_req(4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h0, 1'b1, LAT_NOACC, "range_wrap");
      run_req(4'hB, 64'h0, 64'h400, 64'h0, 64'h0, 1'b1, LAT_NOACC, "range_popq_depth");
      run_req(4'h5, 64'h10, 64'h0, 64'h0, 64'h0123456789ABCDEF, 1'b0, LAT_ACC, "range_low_intact");
   endtask

   task automatic test_no_access();
      run_req(4'h6, 64'h10, 64'h1234, 64'h0, 64'h0, 1'b0, LAT_NOACC, "opq_noaccess");
      run_req(4'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h0, 1'b0, LAT_NOACC, "halt_noaccess");
   endtask

   // A start during XFER is dropped: exactly one done, and the dropped
   // read would have produced the written word with a different latency.
   task automatic test_ignored_start();
      exp_t x;
      int dones;
      x.valm = 64'h0; x.err = 1'b0; x.lat = LAT_ACC; x.name = "ignored_start";
      sb_q.push_back(x);
      icode = 4'hA; valE = 64'h100; valA = 64'hA5A5_5A5A_1234_8765; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      icode = 4'h5; valE = 64'h10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            dones++;
            x = sb_q.pop_front();
            checks++;
            if (valM !== x.valm || dmem_error !== x.err) begin
               errors++;
               $display("FAIL %s result: valM=%h err=%b required %h %b",
                        x.name, valM, dmem_error, x.valm, x.err);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL ignored_start done_count: got %0d required 1", dones);
      end
      run_req(4'h5, 64'h100, 64'h0, 64'h0, 64'hA5A5_5A5A_1234_8765, 1'b0, LAT_ACC, "ignored_start_data");
   endtask

   // start held high through DONE is accepted only on the following IDLE cycle.
   task automatic test_back_to_back();
      int lat;
      icode = 4'h6; start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b first_done: got %b required 1", done);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b done_start_ignored: done=%b busy=%b required 0 0", done, busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b second_accept: done=%b required 1 at cycle %0d", done, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      run_req(4'h4, 64'h20, 64'h0, 64'h0, 64'h0, 1'b0, LAT_ACC, "clear_0x20");
      icode = 4'hA; valE = 64'h20; valA = 64'hFFFFFFFFFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || valM !== 64'h0 || dmem_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid outputs: busy=%b done=%b valM=%h err=%b required 0 0 0 0",
                  busy, done, valM, dmem_error);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_req(4'hB, 64'h0, 64'h20, 64'h0, 64'h00000000FFFFFFFF, 1'b0, LAT_ACC, "reset_mid_popq");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; icode = 4'h0;
      valE = 64'h0; valA = 64'h0; valP = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_call_ret();
      test_range();
      test_no_access();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the Y86-64 SEQ datapath, directly downstream of the execute stage.
- Consumes icode, valE, valA and valP, and performs the data-memory read or write that the instruction requires.
- Returns valM to write-back and dmem_error to status logic.
- Owns a byte-addressed little-endian data memory and moves one byte per cycle; a 64-bit access takes 8 transfer cycles, with start/done handshake to the sequencer.

Parameters:
- DEPTH, 1024, data-memory size in bytes.
- ADDR_W, 64, address width taken from valE/valA.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- icode  in  4  instruction code from execute.
- valE  in  64  ALU result (address for rmmovq, mrmovq, call, pushq).
- valA  in  64  store data for rmmovq/pushq; address for ret/popq.
- valP  in  64  return address stored by call.
- valM  out  64  loaded word.
- done  out  1  one-cycle pulse, operation complete.
- busy  out  1  high in XFER and DONE.
- dmem_error  out  1  address out of range; valid while done=1, held until next accept.

Behaviour:
- Reset values: valM=0, done=0, busy=0, dmem_error=0, state=IDLE, byte counter=0.
- Reset does not clear memory contents; memory initialises to all-zero at time 0.
- States: IDLE, XFER, DONE.
- Accept: in IDLE with start=1, latch icode, addr, wdata; set dmem_error=0 and valM=0.
- Operation table:
  - icode 4 (rmmovq): write valA to M[valE].
  - icode 5 (mrmovq): read M[valE].
  - icode 8 (call): write valP to M[valE].
  - icode A (pushq): write valA to M[valE].
  - icode 9 (ret): read M[valA].
  - icode B (popq): read M[valA].
  - Any other icode: no access.
- Range check at accept, computed in ADDR_W+1 bits so that addr+7 cannot wrap.
  - Error when addr+7 > DEPTH-1, or addr >= DEPTH.
  - On error: no memory byte touched; next state DONE with dmem_error=1.
- No-access icode: IDLE -> DONE in one cycle. done is high in the cycle after accept; valM=0.
- Access icode in range: IDLE -> XFER with counter k=0..7.
  - Each XFER cycle handles byte addr+k.
  - Writes: M[addr+k] <= wdata[8k+7:8k].
  - Reads: valM[8k+7:8k] <= M[addr+k].
  - After k=7: -> DONE.
- Access latency: done asserted exactly 9 cycles after the accepting edge (8 XFER + 1 DONE).
- DONE lasts one cycle, then -> IDLE. done=1 only in DONE.
- valM and dmem_error hold their values until the next accept.
- start while busy: ignored, not queued. A start coinciding with DONE is also ignored; the earliest new accept is the following IDLE cycle.
- Unaligned addresses are legal.
- Read-after-write across separate requests returns the new data.
- Reset mid-XFER: control returns to IDLE immediately and outputs go to their reset values. Bytes already written stay written; there is no rollback.
- Input changes after accept have no effect (latched copies are used).

Decomposition:
- Shared package (y86_defs):
  - icode constants: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - State encoding for IDLE/XFER/DONE.
  - Constant WORD_BYTES=8.
- One natural sub-module: dmem_byte_ram.
  - DEPTH x 8 array with a single synchronous port: addr, we, wdata, rdata.
  - Read-first behaviour.
- Address mux, range check, FSM and valM assembly live in memory_access.

Test Plan:
- rmmovq write then mrmovq read:
  - Stimulus: icode=4, valE=0x10, valA=0x0123456789ABCDEF, start; then icode=5, valE=0x10, start.
  - Response: first done after 9 cycles; bytes M[0x10..0x17]=EF,CD,AB,89,67,45,23,01. Second done after 9 cycles with valM=0x0123456789ABCDEF and dmem_error=0.
- call/ret pair:
  - Stimulus: icode=8, valE=0x3F8, valP=0x42; then icode=9, valA=0x3F8.
  - Response: valM=0x42 at second done.
- Boundary range check:
  - Stimulus: valE=0x3F8 (DEPTH=1024), mrmovq.
  - Response: no error.
  - Stimulus: valE=0x3F9, mrmovq.
  - Response: dmem_error=1, done one cycle after accept, memory unchanged.
  - Stimulus: valE=0xFFFFFFFFFFFFFFFC.
  - Response: dmem_error=1, no wrap.
- Non-memory op and ignored start:
  - Stimulus: icode=6 with start.
  - Response: done next cycle, valM=0.
  - Stimulus: during an access, pulse start with a different icode.
  - Response: the second request is ignored; exactly one done pulse.
- Reset mid-operation:
  - Stimulus: assert rst on the 4th XFER cycle of a pushq, valA=0xFFFFFFFFFFFFFFFF, valE=0x20.
  - Response: busy=0 and done=0 immediately. M[0x20..0x23]=FF, M[0x24..0x27]=00. A later popq with valA=0x20 returns valM=0x00000000FFFFFFFF.
